// File: rtl/ikaopll_pg_sequencer.sv
// Slot sequencer and phase-reset scheduler for the PG datapath.
// Runs the 18-slot operator counter, tracks melodic/rhythm key-on edges and
// issues one phase-clear per affected slot, aligned to that slot's PG cycle.
module ikaopll_pg_sequencer #(
    parameter int RST_OFFSET = 1,
    parameter int NUM_CH     = 9
) (
    input  logic       i_EMUCLK,
    input  logic       i_RST,
    input  logic       i_phi1_NCEN_n,
    input  logic       i_KON_WR,
    input  logic [3:0] i_KON_CH,
    input  logic       i_KON_VAL,
    input  logic       i_RHYTHM_EN,
    input  logic [4:0] i_RHYTHM_KON,
    output logic [4:0] o_CYCLE_CNT,
    output logic       o_CYCLE_17,
    output logic       o_CYCLE_20,
    output logic       o_CYCLE_21,
    output logic       o_PG_PHASE_RST,
    output logic       o_BUSY
);
    localparam int NSLOT = 2 * NUM_CH;
    localparam logic [4:0] CNT_MAX = 5'(NSLOT - 1);

    // rhythm key-on bit positions within {BD,SD,TT,TC,HH}
    localparam int R_BD = 4;
    localparam int R_SD = 3;
    localparam int R_TT = 2;
    localparam int R_TC = 1;
    localparam int R_HH = 0;

    logic [4:0]        cnt_q, cnt_d;
    logic [NUM_CH-1:0] kon_q, kon_d;
    logic [4:0]        rkon_z_q, rkon_z_d;
    logic [NSLOT-1:0]  pend_q, pend_d;
    logic              phase_rst_q, phase_rst_d;
    logic              busy_q, busy_d;

    logic [4:0]       cnt_next;
    logic [5:0]       tgt_sum;
    logic [4:0]       tgt;
    logic [NSLOT-1:0] set_mask;
    logic [4:0]       rise;
    logic             en;

    assign en = ~i_phi1_NCEN_n;

    // Next counter value and the slot whose clear is presented alongside it
    always_comb begin
        cnt_next = (cnt_q == CNT_MAX) ? 5'd0 : cnt_q + 5'd1;
        tgt_sum  = {1'b0, cnt_next} + 6'(RST_OFFSET);
        tgt      = (tgt_sum >= 6'(NSLOT)) ? 5'(tgt_sum - 6'(NSLOT)) : tgt_sum[4:0];
    end

    // Key-on edge detection; runs every clock regardless of slot enable
    always_comb begin
        kon_d    = kon_q;
        rkon_z_d = i_RHYTHM_KON;
        set_mask = '0;
        rise     = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_KON_WR && i_KON_CH == 4'(c)) begin
                kon_d[c] = i_KON_VAL;
                if (!kon_q[c] && i_KON_VAL) begin
                    set_mask[2*c]   = 1'b1;
                    set_mask[2*c+1] = 1'b1;
                end
            end
        end
        // rhythm edges are dropped outside rhythm mode, but the delay still tracks
        if (i_RHYTHM_EN)
            rise = i_RHYTHM_KON & ~rkon_z_q;
        set_mask[12] = set_mask[12] | rise[R_BD];
        set_mask[13] = set_mask[13] | rise[R_BD];
        set_mask[14] = set_mask[14] | rise[R_HH];
        set_mask[15] = set_mask[15] | rise[R_SD];
        set_mask[16] = set_mask[16] | rise[R_TT];
        set_mask[17] = set_mask[17] | rise[R_TC];
    end

    // Pending-clear bookkeeping; a same-edge set at tgt is served immediately
    always_comb begin
        cnt_d       = cnt_q;
        pend_d      = pend_q | set_mask;
        phase_rst_d = phase_rst_q;
        if (en) begin
            cnt_d        = cnt_next;
            phase_rst_d  = ~(pend_q[tgt] | set_mask[tgt]);
            pend_d[tgt]  = 1'b0;
        end
        busy_d = |pend_d;
    end

    // State registers with synchronous reset
    always_ff @(posedge i_EMUCLK) begin
        if (i_RST) begin
            cnt_q       <= '0;
            kon_q       <= '0;
            rkon_z_q    <= '0;
            pend_q      <= '0;
            phase_rst_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            kon_q       <= kon_d;
            rkon_z_q    <= rkon_z_d;
            pend_q      <= pend_d;
            phase_rst_q <= phase_rst_d;
            busy_q      <= busy_d;
        end
    end

    assign o_CYCLE_CNT    = cnt_q;
    assign o_CYCLE_17     = (cnt_q == 5'd17);
    assign o_CYCLE_20     = (cnt_q == 5'd2);
    assign o_CYCLE_21     = (cnt_q == 5'd3);
    assign o_PG_PHASE_RST = phase_rst_q;
    assign o_BUSY         = busy_q;
endmodule
